// File: rtl/logic16_pkg.sv
// Shared constants and encodings for the 16-bit logic datapath arbiter.
// Imported by the interface, the logic unit and the arbiter top.
package logic16_pkg;

    localparam int N_REQ = 4;
    localparam int WIDTH = 16;
    localparam int ID_W  = $clog2(N_REQ);

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_NOT = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_e;

endpackage

// File: rtl/logic16_arbiter_if.sv
// Request/response bundle between the requesters, the result consumer and the arbiter.
// Requester i owns slice [i*WIDTH +: WIDTH] of req_a/req_b and [i*2 +: 2] of req_op.
interface logic16_arbiter_if;
    import logic16_pkg::*;

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;
    logic [N_REQ*2-1:0]     req_op;
    logic                   resp_valid;
    logic                   resp_ready;
    logic [ID_W-1:0]        resp_id;
    logic [WIDTH-1:0]       resp_data;

    modport master (
        output req_valid, req_a, req_b, req_op, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_data
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, resp_ready,
        output req_ready, resp_valid, resp_id, resp_data
    );

endinterface

// File: rtl/logic16_gates.sv
// The 16-bit bitwise gate chips that the shared logic unit is built from.
module and_16bit_chip (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] y
);
    assign y = a & b;
endmodule

module or_16bit_chip (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] y
);
    assign y = a | b;
endmodule

module xor_16bit_chip (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] y
);
    assign y = a ^ b;
endmodule

module not_16bit_chip (
    input  logic [15:0] a,
    output logic [15:0] y
);
    assign y = ~a;
endmodule

// File: rtl/logic16_unit.sv
// Combinational logic unit: one instance of each gate chip and an opcode-driven result mux.
module logic16_unit
    import logic16_pkg::*;
(
    input  op_e              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0] y_and, y_or, y_xor, y_not;

    and_16bit_chip u_and (.a(a), .b(b), .y(y_and));
    or_16bit_chip  u_or  (.a(a), .b(b), .y(y_or));
    xor_16bit_chip u_xor (.a(a), .b(b), .y(y_xor));
    not_16bit_chip u_not (.a(a), .y(y_not));

    // NOTE: y gets a value before the case so no path through this block can infer a latch.
    always_comb begin
        y = y_and;
        case (op)
            OP_AND:  y = y_and;
            OP_OR:   y = y_or;
            OP_XOR:  y = y_xor;
            OP_NOT:  y = y_not;
            default: y = y_and;
        endcase
    end

endmodule

// File: rtl/logic16_arbiter.sv
// Round-robin arbiter sharing one logic unit among N_REQ requesters.
// One operation in flight at a time: IDLE accepts, EXEC computes, RESP holds the result until taken.
module logic16_arbiter
    import logic16_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    logic16_arbiter_if.slave  bus,
    output logic              busy
);

    state_e           state_q, state_d;
    logic [ID_W-1:0]  rr_ptr_q;
    logic [ID_W-1:0]  winner_q;
    logic [ID_W-1:0]  pick;
    logic [ID_W-1:0]  idx;
    logic             found;
    logic             accept;
    logic [WIDTH-1:0] a_q, b_q;
    op_e              op_q;
    logic [WIDTH-1:0] unit_y;
    logic             resp_valid_q;
    logic [ID_W-1:0]  resp_id_q;
    logic [WIDTH-1:0] resp_data_q;

    // First valid requester at or after rr_ptr, wrapping through the ID space.
    always_comb begin
        found = 1'b0;
        pick  = rr_ptr_q;
        idx   = rr_ptr_q;
        for (int i = 0; i < N_REQ; i++) begin
            idx = rr_ptr_q + ID_W'(i);
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    assign accept = (state_q == IDLE) && found;

    // Gated with rst_n so no requester sees a grant while reset is held.
    always_comb begin
        bus.req_ready = '0;
        if (accept && rst_n) begin
            bus.req_ready[pick] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (found) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (bus.resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    logic16_unit u_unit (
        .op (op_q),
        .a  (a_q),
        .b  (b_q),
        .y  (unit_y)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            winner_q     <= '0;
            // NOTE: operand latches are reset along with the control state so nothing downstream sees X.
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= OP_AND;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_data_q  <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (found) begin
                        a_q      <= bus.req_a[pick*WIDTH +: WIDTH];
                        b_q      <= bus.req_b[pick*WIDTH +: WIDTH];
                        op_q     <= op_e'(bus.req_op[pick*2 +: 2]);
                        winner_q <= pick;
                    end
                end
                EXEC: begin
                    resp_data_q  <= unit_y;
                    resp_id_q    <= winner_q;
                    resp_valid_q <= 1'b1;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        rr_ptr_q     <= winner_q + ID_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_data  = resp_data_q;
    assign busy           = (state_q != IDLE);

endmodule

// File: doc/logic16_arbiter.md
# logic16_arbiter

Shared-resource controller for the 16-bit bitwise logic datapath (AND/OR/XOR/NOT chips). Up to four requesters submit operand pairs plus an opcode. A round-robin arbiter grants one request at a time to a single logic unit, registers the result and returns it with the requester ID over a valid/ready response channel. It sits between the CPU-side issue logic and the combinational 16-bit gate chips, so one set of chips serves all clients.

## Interface
- N_REQ, 4: number of requesters; fixed at 4 for this revision
- WIDTH, 16: operand/result width in bits
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  N_REQ  per-requester request valid
- req_ready  out  N_REQ  per-requester accept (one-hot or zero)
- req_a  in  N_REQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH]
- req_b  in  N_REQ*WIDTH  operand B, same packing
- req_op  in  N_REQ*2  opcode: 00 AND, 01 OR, 10 XOR, 11 NOT A (B ignored)
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_id  out  2  index of requester that owns resp_data
- resp_data  out  WIDTH  registered result
- busy  out  1  high when state is not IDLE

## Operation
- The FSM has three states: IDLE, EXEC, RESP.
- IDLE: if any req_valid is high, the winner is the first set bit at or after rr_ptr, searching upward with wrap (rr_ptr, rr_ptr+1, …, N_REQ-1, 0, …).
  - req_ready[winner] is driven high combinationally in the same cycle.
  - On that edge the block latches a, b, op and winner. Next state is EXEC.
- EXEC: the logic unit evaluates the latched operands. The result is registered into resp_data, resp_id is set to winner, and resp_valid is set. Next state is RESP. No new request is accepted.
- RESP: resp_valid holds high, and resp_data/resp_id hold stable until resp_ready is sampled high.
  - On the handshake edge, resp_valid clears, rr_ptr becomes (winner+1) mod N_REQ, and next state is IDLE.
- req_ready is zero in EXEC and RESP. A requester must hold req_valid and its operands stable until it sees its req_ready.
- Requests that are not granted are not dropped. They stay pending on the requester side.
- Width rule: purely bitwise, with no carry or overflow. NOT A yields ~a across all WIDTH bits.
- Reset values: state=IDLE, rr_ptr=0, resp_valid=0, resp_id=0, resp_data=0, busy=0. req_ready is 0 for the duration of reset.
- Reset mid-operation: an asserted rst_n=0 aborts any EXEC/RESP immediately and asynchronously. The in-flight result is discarded and is not replayed.

## Timing
- Minimum latency is 2 cycles from the accept edge (req_valid & req_ready) to resp_valid high (EXEC, then RESP on the next edge).
- Throughput is at most one operation per 3 cycles (IDLE accept, EXEC, RESP with resp_ready=1). There is no overlap between responses and new grants.
- If resp_ready is already high when resp_valid rises, the handshake completes on the first RESP cycle.
- Simultaneous req_valid on all lines are granted in rotating order 0,1,2,3,0,… from reset, one per transaction.
- req_valid falling while in EXEC/RESP has no effect on the in-flight operation.
- The block contains no combinational path from resp_ready to req_ready.

## Structure
- Package logic16_pkg holds WIDTH=16, the 2-bit op encodings (OP_AND, OP_OR, OP_XOR, OP_NOT) and the state encoding (IDLE, EXEC, RESP).
- Sub-module logic16_unit is a combinational op/a/b -> out mux. It is built by instantiating the existing and_16bit_chip, or_16bit_chip, xor_16bit_chip and not_16bit_chip gates.
- The arbiter (priority search from rr_ptr), FSM and output registers live in logic16_arbiter.

## Test plan
- Reset: hold rst_n=0 with random inputs. Required: resp_valid=0, req_ready=0000, resp_data=0x0000, busy=0.
- Single OR: requester 2 sends a=1010001110001100, b=1100011100000111, op=01, with resp_ready=1. Required:
  - req_ready=0100 in the accept cycle
  - 2 cycles later, resp_valid=1, resp_id=2, resp_data=1110011110001111
- All ops from requester 0 with the same operands:
  - AND gives 1000001100000100
  - XOR gives 0110010010001011
  - NOT gives 0101110001110011
  - 0x0000 OR 0xFFFF gives 0xFFFF
- Round-robin: all four req_valid held high with resp_ready=1. Required grant order 0,1,2,3,0, one grant every 3 cycles, each resp_id matching its grant.
- Backpressure: resp_ready=0 for 5 cycles after resp_valid. Required: resp_data/resp_id stable, req_ready=0000, busy=1. Raising resp_ready returns the FSM to IDLE on the next edge.
- Reset mid-operation: pulse rst_n low during RESP. Required: resp_valid drops immediately and rr_ptr returns to 0. The next grant with all requesters valid goes to requester 0.
